// File: rtl/nibble_serial_adder_if.sv
// Request, 4-bit adder and result signals of the nibble-serial adder.
// The master side is the environment: operand source, external 4-bit adder and result consumer.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start_valid, op_a, op_b, cin, add_sum, add_cout, res_ready,
        input  start_ready, add_a, add_b, add_cin, res_valid, result, cout, overflow
    );

    modport slave (
        input  start_valid, op_a, op_b, cin, add_sum, add_cout, res_ready,
        output start_ready, add_a, add_b, add_cin, res_valid, result, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Sequences a WIDTH-bit add through an external 4-bit adder, one nibble per cycle,
// LSB nibble first, with the carry held in a register between nibbles.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] result_r;
    logic [IDX_W-1:0] idx_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic             carry_r;
    logic             cout_r;
    logic             overflow_r;
    logic             start_ready_r;
    logic             res_valid_r;
    logic             take_s;
    logic             last_s;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        take_s  = 1'b0;
        last_s  = (idx_r == IDX_W'(NIBBLES - 1));
        case (state_r)
            IDLE: begin
                if (bus.start_valid && start_ready_r) begin
                    state_s = ADD;
                    take_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ADD;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake flags registered from the upcoming state so they never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            start_ready_r <= 1'b1;
            res_valid_r   <= 1'b0;
        end else begin
            start_ready_r <= (state_s == IDLE);
            res_valid_r   <= (state_s == DONE);
        end
    end

    // Operand capture, nibble stepping and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r     <= '0;
            b_sh_r     <= '0;
            result_r   <= '0;
            idx_r      <= '0;
            a_msb_r    <= 1'b0;
            b_msb_r    <= 1'b0;
            carry_r    <= 1'b0;
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        a_sh_r  <= bus.op_a;
                        b_sh_r  <= bus.op_b;
                        a_msb_r <= bus.op_a[WIDTH-1];
                        b_msb_r <= bus.op_b[WIDTH-1];
                        carry_r <= bus.cin;
                        idx_r   <= '0;
                    end
                end
                ADD: begin
                    // Operands shift right so the live nibble is always bits [3:0]
                    // and both shifters are empty again once the add completes.
                    result_r[{idx_r, 2'b00} +: 4] <= bus.add_sum;
                    a_sh_r <= {4'h0, a_sh_r[WIDTH-1:4]};
                    b_sh_r <= {4'h0, b_sh_r[WIDTH-1:4]};
                    if (last_s) begin
                        cout_r     <= bus.add_cout;
                        overflow_r <= (a_msb_r == b_msb_r) && (bus.add_sum[3] != a_msb_r);
                        carry_r    <= 1'b0;
                        idx_r      <= '0;
                    end else begin
                        carry_r <= bus.add_cout;
                        idx_r   <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.result      = result_r;
    assign bus.cout        = cout_r;
    assign bus.overflow    = overflow_r;
    assign bus.add_a       = a_sh_r[3:0];
    assign bus.add_b       = b_sh_r[3:0];
    assign bus.add_cin     = carry_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a behavioural 4-bit adder and a result scoreboard.
module tb_nibble_serial_adder;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'h0, bus.add_cin};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        logic [WIDTH:0] s;
        exp_t e;
        s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        e.res = s[WIDTH-1:0];
        e.co  = s[WIDTH];
        e.ov  = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    task automatic send(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        bit got;
        got = 1'b0;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.cin         = c;
        bus.start_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bus.start_ready) got = 1'b1;
            step();
        end
        if (got) sb.push_back(model(a, b, c));
        check({tag, "_handshake"}, 32'(got), 32'd1);
        bus.start_valid = 1'b0;
        bus.op_a        = WIDTH'($urandom);
        bus.op_b        = WIDTH'($urandom);
        bus.cin         = 1'($urandom);
    endtask

    task automatic pop_cmp(input string tag, output exp_t e);
        e = '0;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(bus.result), 32'(e.res));
            check({tag, "_cout"}, 32'(bus.cout), 32'(e.co));
            check({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ov));
        end
    endtask

    task automatic wait_res(input string tag, output int lat, output exp_t e);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        e    = '0;
        for (int n = 0; n < 30 && !seen; n++) begin
            if (bus.res_valid) begin
                seen = 1'b1;
            end else begin
                step();
                lat++;
            end
        end
        check({tag, "_res_valid_seen"}, 32'(seen), 32'd1);
        if (seen) pop_cmp(tag, e);
    endtask

    task automatic run_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        int   lat;
        exp_t e;
        send(tag, a, b, c);
        wait_res(tag, lat, e);
        check({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
        check({tag, "_ready_in_done"}, 32'(bus.start_ready), 32'd0);
        step();
        check({tag, "_valid_dropped"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        int   lat;
        int   nres;
        int   t;
        int   last_t;
        bit   hs;
        bit   stray;
        exp_t e;
        logic [WIDTH-1:0] ca;
        logic [WIDTH-1:0] cb;
        logic             cc;

        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.cin         = 1'b0;

        // Reset values
        rst = 1'b1;
        step();
        step();
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_add_a", 32'(bus.add_a), 32'd0);
        check("rst_add_b", 32'(bus.add_b), 32'd0);
        check("rst_add_cin", 32'(bus.add_cin), 32'd0);
        rst = 1'b0;
        step();

        // Basic arithmetic and boundary sums
        run_one("basic",     16'h1234, 16'h4321, 1'b0);
        run_one("wrap",      16'hFFFF, 16'h0001, 1'b0);
        run_one("cin_only",  16'h0000, 16'h0000, 1'b1);
        run_one("pos_ovf",   16'h7FFF, 16'h0001, 1'b0);
        run_one("neg_ovf",   16'h8000, 16'h8000, 1'b0);
        run_one("cin_chain", 16'h7FFF, 16'h0000, 1'b1);

        // Backpressure: hold DONE for 5 cycles with a stray start pulse
        bus.res_ready = 1'b0;
        send("bp", 16'hA5A5, 16'h5A5B, 1'b1);
        wait_res("bp", lat, e);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.start_valid = 1'b1;
                bus.op_a        = 16'h1111;
                bus.op_b        = 16'h2222;
            end
            step();
            bus.start_valid = 1'b0;
            check("bp_hold_valid", 32'(bus.res_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.start_ready), 32'd0);
            check("bp_hold_result", 32'(bus.result), 32'(e.res));
            check("bp_hold_cout", 32'(bus.cout), 32'(e.co));
            check("bp_hold_overflow", 32'(bus.overflow), 32'(e.ov));
        end
        bus.res_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(bus.res_valid), 32'd0);
        check("bp_release_ready", 32'(bus.start_ready), 32'd1);
        run_one("after_bp", 16'h0F0F, 16'h00F1, 1'b0);

        // Reset while the nibble index is 2
        send("abort", 16'h1357, 16'h2468, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (sb.size() != 0) void'(sb.pop_back());
        check("abort_ready", 32'(bus.start_ready), 32'd1);
        check("abort_valid", 32'(bus.res_valid), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_add_a", 32'(bus.add_a), 32'd0);
        check("abort_add_cin", 32'(bus.add_cin), 32'd0);
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.res_valid) stray = 1'b1;
        end
        check("abort_no_valid", 32'(stray), 32'd0);
        run_one("after_abort", 16'hC3C3, 16'h3C3D, 1'b0);

        // Back-to-back with start_valid held high and operands changing every cycle
        bus.res_ready   = 1'b1;
        bus.start_valid = 1'b1;
        bus.op_a        = WIDTH'($urandom);
        bus.op_b        = WIDTH'($urandom);
        bus.cin         = 1'($urandom);
        nres   = 0;
        t      = 0;
        last_t = 0;
        for (int n = 0; n < 80 && nres < 5; n++) begin
            hs = bus.start_valid && bus.start_ready;
            ca = bus.op_a;
            cb = bus.op_b;
            cc = bus.cin;
            step();
            t++;
            if (hs) sb.push_back(model(ca, cb, cc));
            bus.op_a = WIDTH'($urandom);
            bus.op_b = WIDTH'($urandom);
            bus.cin  = 1'($urandom);
            if (bus.res_valid) begin
                pop_cmp("b2b", e);
                if (nres > 0) check("b2b_interval", 32'(t - last_t), 32'(NIBBLES + 2));
                last_t = t;
                nres++;
            end
        end
        bus.start_valid = 1'b0;
        check("b2b_count", 32'(nres), 32'd5);
        step();
        check("b2b_idle_ready", 32'(bus.start_ready), 32'd1);
        check("b2b_sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequencer that sits directly upstream of the FourBitAdder stage and also consumes its output. It accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake. It feeds the operands to the 4-bit adder one nibble per cycle, LSB nibble first, chaining the carry between nibbles. It then presents the assembled WIDTH-bit sum, carry-out and signed overflow over a valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIBBLES, WIDTH/4, derived number of add cycles; not overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start_valid  input  1  operand request valid
start_ready  output  1  block can accept a request
op_a  input  WIDTH  operand A, sampled on start handshake
op_b  input  WIDTH  operand B, sampled on start handshake
cin  input  1  initial carry-in, sampled on start handshake
add_a  output  4  current A nibble to 4-bit adder
add_b  output  4  current B nibble to 4-bit adder
add_cin  output  1  current carry to 4-bit adder
add_sum  input  4  adder sum, combinational return
add_cout  input  1  adder carry-out, combinational return
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
result  output  WIDTH  assembled sum
cout  output  1  final carry-out of MSB nibble
overflow  output  1  two's-complement overflow

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: state=IDLE; start_ready=1 from the first cycle after reset. res_valid, result, cout, overflow, add_a, add_b, add_cin all 0. The nibble index and the captured operands are cleared.
- States: IDLE, ADD, DONE.
- IDLE:
  - start_ready=1.
  - add_a, add_b and add_cin are driven 0.
  - On start_valid&&start_ready: latch op_a, op_b and cin; nibble index i=0; go to ADD.
- ADD:
  - start_ready=0.
  - add_a=A[4i+3:4i], add_b=B[4i+3:4i]. add_cin = latched cin when i=0, otherwise the registered add_cout of the previous nibble.
  - Each edge writes add_sum into result nibble i and registers add_cout.
  - While i<NIBBLES-1: i increments.
  - At i=NIBBLES-1: cout<=add_cout; overflow <= (A[WIDTH-1]==B[WIDTH-1]) && (add_sum[3]!=A[WIDTH-1]); go to DONE.
- Latency: the handshake occurs on edge k. res_valid is high in the cycle following edge k+NIBBLES, so exactly NIBBLES ADD cycles.
- DONE:
  - res_valid=1; start_ready=0.
  - result, cout and overflow are held stable until res_ready=1 is sampled.
  - On the res_ready edge: go to IDLE and drop res_valid. start_ready=1 in the next cycle. There is no same-cycle restart.
- result is not updated outside ADD. Intermediate nibbles may be visible during ADD, but res_valid=0 then.
- start_valid while busy is ignored. op_a, op_b and cin changes after the handshake have no effect.
- rst asserted in any state, including mid-ADD or DONE: the operation is aborted, no res_valid pulse is produced, and all reset values are restored on that edge.
- Carry chain: the carry is purely sequential between nibbles. There is no combinational path from add_sum or add_cout to add_a, add_b or add_cin.
- Arithmetic is modulo 2^WIDTH. cout is the true unsigned carry out. overflow is signed overflow including the cin contribution.

Test Plan:
- WIDTH=16: op_a=0x1234, op_b=0x4321, cin=0, res_ready=1 -> res_valid exactly 4 cycles after handshake; result=0x5555, cout=0, overflow=0.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1, overflow=0. Also 0x0000+0x0000 with cin=1 -> result=0x0001, cout=0.
- op_a=0x7FFF, op_b=0x0001 -> result=0x8000, cout=0, overflow=1. Also 0x8000+0x8000 -> result=0x0000, cout=1, overflow=1.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> result, cout and overflow stable; start_ready=0; a start_valid pulse is ignored. res_ready=1 -> IDLE, and the next request (0x0F0F+0x00F1) gives 0x1000.
- Reset mid-ADD (rst high at nibble index 2) -> next cycle state IDLE, start_ready=1, result=0, and no res_valid is ever seen. A fresh request afterwards completes correctly.
- Back-to-back: start_valid held high continuously with res_ready=1 -> one result every NIBBLES+2 cycles. Each result matches the operands captured at its own handshake.
